hs_sr_sched: RTL and testbench
==============================

Name: hs_sr_sched

Overview:
Symbol scheduler and load controller for the 10-bit high-speed shift register (hs_sr) on the serial link. It arbitrates between a control-token source and a data-symbol source using valid/ready handshakes. It drives the shift register's load_enable and parallel_in on an 11-cycle frame: 1 load cycle, then 10 shift cycles. When the link is enabled and neither source is ready, it inserts an idle token so the link stays continuous.

Parameters:
SYM_W, 10, symbol width; must match the shift register width
IDLE_SYM, 10'h354, token loaded when the link is enabled and no source is valid
CNT_W, 4, bit counter width; must satisfy 2**CNT_W >= SYM_W

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
enable  in  1  link enable; sampled only at arbitration points
ctrl_valid  in  1  control token available
ctrl_sym  in  SYM_W  control token
ctrl_ready  out  1  combinational; token accepted this cycle when ctrl_valid=1
data_valid  in  1  data symbol available
data_sym  in  SYM_W  data symbol
data_ready  out  1  combinational; symbol accepted this cycle when data_valid=1
load_enable  out  1  registered; drives shift-register load_enable
parallel_in  out  SYM_W  registered; drives shift-register parallel_in
src  out  2  registered source of current symbol: 00 idle fill, 01 data, 10 ctrl
bit_cnt  out  CNT_W  index of the bit currently on serial_out during SHIFT, else 0
busy  out  1  1 whenever state != IDLE
sym_done  out  1  combinational pulse in the last SHIFT cycle (bit_cnt = SYM_W-1)

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, load_enable=0, parallel_in=0, src=00, bit_cnt=0, last_grant=data. A symbol in flight is abandoned. Reset has priority over all other events.
- States:
  - IDLE: nothing in flight.
  - LOAD: 1 cycle, load_enable=1.
  - SHIFT: SYM_W cycles, bit_cnt counts 0..SYM_W-1.
- Arbitration point: any IDLE cycle with enable=1, or the last SHIFT cycle. Grants happen only at arbitration points.
- Grant rule (default): ctrl_valid wins over data_valid.
  - ctrl_ready=1 iff at an arbitration point, enable=1 and ctrl_valid=1.
  - data_ready=1 iff at an arbitration point, enable=1, data_valid=1 and ctrl_valid=0.
  - Both readys are 0 at every other time.
- On a grant: the winning symbol is registered into parallel_in and src is set (10 ctrl, 01 data). Next state is LOAD.
- IDLE with enable=1 and no valid: stay in IDLE, no load.
- Last SHIFT cycle, enable=1, no valid: parallel_in<=IDLE_SYM, src<=00, go to LOAD. No ready is asserted.
- Last SHIFT cycle, enable=0: go to IDLE with no grant. parallel_in and src hold their values.
- Transitions:
  - LOAD -> SHIFT, bit_cnt=0.
  - In SHIFT, bit_cnt increments each cycle.
  - At bit_cnt=SYM_W-1, sym_done=1 and the arbitration rule applies.
- Latency:
  - Grant at cycle t: load_enable=1 at t+1; bit 0 on serial_out at t+2; bit SYM_W-1 at t+SYM_W+1.
  - Back-to-back frames: load_enable pulses every SYM_W+1 cycles. The serial line carries 0 during each load cycle because the shift register masks serial_out while loading.
- enable deasserted mid-SHIFT: the current symbol completes, then the block goes to IDLE. enable changes during LOAD or mid-SHIFT have no effect.
- Source valid/symbol changes outside arbitration points are ignored. A source must hold valid and its symbol until it sees ready (valid&ready = transfer).
- At most one ready is high in any cycle.

Optional Feature:
RR_ARB_EN
- Defined: when both ctrl_valid and data_valid are 1 at an arbitration point, grant goes to the source opposite last_grant. last_grant updates only on real grants; idle fills do not change it. Reset value is data, so ctrl wins the first tie. A single valid source is always granted.
- Undefined: fixed priority, ctrl over data; the last_grant register is not built.

Test Plan:
1. rst 2 cycles; enable=1; data_valid=1, data_sym=10'h2AA in IDLE -> data_ready=1 that cycle. Next cycle: load_enable=1, parallel_in=10'h2AA, src=01. Then 10 SHIFT cycles, bit_cnt 0..9, sym_done at bit_cnt=9.
2. data_valid held high with new symbols each grant -> load_enable pulses exactly every 11 cycles; one data_ready per frame; serial bits match each symbol LSB first.
3. After one data symbol, valids=0 with enable=1 -> at the end of the frame: parallel_in=10'h354, src=00, no ready; idle frames repeat every 11 cycles.
4. ctrl_valid=1 (10'h0AB) and data_valid=1 (10'h1CD) held for 3 frames:
   - Default: ctrl granted all 3 frames, data_ready never 1.
   - With RR_ARB_EN: grants go ctrl, data, ctrl.
5. enable dropped at bit_cnt=4 with data_valid=1 -> symbol finishes to bit_cnt=9; no ready asserted; state IDLE, busy=0; load_enable stays 0 until enable=1 again.
6. rst asserted at bit_cnt=5 with data_valid=1 -> next cycle busy=0, load_enable=0, parallel_in=0, src=00. First cycle after rst release with enable=1: data_ready=1 (re-grant).

Source files
------------

// File: rtl/hs_sr_sched.sv
// hs_sr_sched: symbol scheduler and load controller for the 10-bit hs_sr
// shift register. It arbitrates between a control-token source and a
// data-symbol source, and runs an 11-cycle frame (1 LOAD cycle, then SYM_W
// SHIFT cycles). While the link is enabled and no source is valid at the end
// of a frame, it loads an idle token so the serial line never goes quiet.
//
// Optional build macro: RR_ARB_EN. When it is defined, a tie between the two
// sources is broken round-robin. When it is undefined, ctrl always wins a tie.
//
// Ports:
//   clk, rst            clock (rising edge); synchronous active-high reset
//   enable              link enable, sampled only at arbitration points
//   ctrl_valid/ctrl_sym control token offer
//   ctrl_ready          comb; control token accepted this cycle
//   data_valid/data_sym data symbol offer
//   data_ready          comb; data symbol accepted this cycle
//   load_enable         registered; shift-register load strobe
//   parallel_in         registered; shift-register parallel load value
//   src                 registered; 00 idle fill, 01 data, 10 ctrl
//   bit_cnt             index of the bit on serial_out during SHIFT, else 0
//   busy                high whenever a frame is in flight
//   sym_done            comb; high in the last SHIFT cycle
module hs_sr_sched #(
    parameter int unsigned             SYM_W    = 10,
    parameter logic [SYM_W-1:0]        IDLE_SYM = 10'h354,
    parameter int unsigned             CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ctrl_valid,
    input  logic [SYM_W-1:0] ctrl_sym,
    output logic             ctrl_ready,
    input  logic             data_valid,
    input  logic [SYM_W-1:0] data_sym,
    output logic             data_ready,
    output logic             load_enable,
    output logic [SYM_W-1:0] parallel_in,
    output logic [1:0]       src,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             busy,
    output logic             sym_done
);

    localparam logic [1:0]       SRC_IDLE = 2'b00;
    localparam logic [1:0]       SRC_DATA = 2'b01;
    localparam logic [1:0]       SRC_CTRL = 2'b10;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SYM_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [SYM_W-1:0]   pin_q, pin_d;
    logic [1:0]         src_q, src_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               le_q, le_d;
    logic               ctrl_win;
    logic               data_win;
    logic               last_bit;

`ifdef RR_ARB_EN
    // 1 = ctrl was the last real grant, 0 = data (reset value)
    logic               last_ctrl_q, last_ctrl_d;

    // On a tie, grant the source opposite the previous real grant
    assign ctrl_win = ctrl_valid && (!data_valid || !last_ctrl_q);
`else
    assign ctrl_win = ctrl_valid;
`endif
    assign data_win = data_valid && !ctrl_win;
    assign last_bit = (cnt_q == LAST_BIT);

    // Next-state, grant and handshake logic
    always_comb begin
        state_d    = state_q;
        pin_d      = pin_q;
        src_d      = src_q;
        cnt_d      = '0;
        le_d       = 1'b0;
        ctrl_ready = 1'b0;
        data_ready = 1'b0;
        sym_done   = 1'b0;
`ifdef RR_ARB_EN
        last_ctrl_d = last_ctrl_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (enable && (ctrl_win || data_win)) begin
                    ctrl_ready = ctrl_win;
                    data_ready = data_win;
                    pin_d      = ctrl_win ? ctrl_sym : data_sym;
                    src_d      = ctrl_win ? SRC_CTRL : SRC_DATA;
                    state_d    = ST_LOAD;
                    le_d       = 1'b1;
`ifdef RR_ARB_EN
                    last_ctrl_d = ctrl_win;
`endif
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (last_bit) begin
                    sym_done = 1'b1;
                    if (enable) begin
                        state_d = ST_LOAD;
                        le_d    = 1'b1;
                        if (ctrl_win || data_win) begin
                            ctrl_ready = ctrl_win;
                            data_ready = data_win;
                            pin_d      = ctrl_win ? ctrl_sym : data_sym;
                            src_d      = ctrl_win ? SRC_CTRL : SRC_DATA;
`ifdef RR_ARB_EN
                            last_ctrl_d = ctrl_win;
`endif
                        end else begin
                            // Idle fill keeps the link continuous
                            pin_d = IDLE_SYM;
                            src_d = SRC_IDLE;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pin_q   <= '0;
            src_q   <= SRC_IDLE;
            cnt_q   <= '0;
            le_q    <= 1'b0;
`ifdef RR_ARB_EN
            last_ctrl_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pin_q   <= pin_d;
            src_q   <= src_d;
            cnt_q   <= cnt_d;
            le_q    <= le_d;
`ifdef RR_ARB_EN
            last_ctrl_q <= last_ctrl_d;
`endif
        end
    end

    assign load_enable = le_q;
    assign parallel_in = pin_q;
    assign src         = src_q;
    assign bit_cnt     = cnt_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hs_sr_sched.sv
// Directed bench for hs_sr_sched, with a behavioural model of the hs_sr
// shift register on the outputs so that the serial bit order can be checked.
module tb_hs_sr_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       ctrl_valid;
    logic [9:0] ctrl_sym;
    logic       ctrl_ready;
    logic       data_valid;
    logic [9:0] data_sym;
    logic       data_ready;
    logic       load_enable;
    logic [9:0] parallel_in;
    logic [1:0] src;
    logic [3:0] bit_cnt;
    logic       busy;
    logic       sym_done;

    int passed = 0;
    int total  = 0;

    hs_sr_sched dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .ctrl_valid  (ctrl_valid),
        .ctrl_sym    (ctrl_sym),
        .ctrl_ready  (ctrl_ready),
        .data_valid  (data_valid),
        .data_sym    (data_sym),
        .data_ready  (data_ready),
        .load_enable (load_enable),
        .parallel_in (parallel_in),
        .src         (src),
        .bit_cnt     (bit_cnt),
        .busy        (busy),
        .sym_done    (sym_done)
    );

    always #5 clk = ~clk;

    // hs_sr model: it loads on load_enable, otherwise it shifts right and
    // sends the LSB first. serial_out is masked while loading.
    logic [9:0] sr_q = '0;
    logic       serial_out;
    always @(posedge clk) begin
        if (load_enable) sr_q <= parallel_in;
        else             sr_q <= sr_q >> 1;
    end
    assign serial_out = load_enable ? 1'b0 : sr_q[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [9:0] syms [3];
    logic [9:0] prev;
    logic       exp_ctrl;

    initial begin
        syms[0] = 10'h2D1; syms[1] = 10'h13C; syms[2] = 10'h3E7;
        rst = 1'b1; enable = 1'b0;
        ctrl_valid = 1'b0; ctrl_sym = '0; data_valid = 1'b0; data_sym = '0;

        // Reset
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_le", 32'(load_enable), 0);
        chk("rst_pin", 32'(parallel_in), 0);
        chk("rst_src", 32'(src), 0);
        chk("rst_cnt", 32'(bit_cnt), 0);
        rst = 1'b0;

        // 1: single data grant from IDLE, then a full frame
        enable = 1'b1; data_valid = 1'b1; data_sym = 10'h2AA;
        #1;
        chk("t1_dready", 32'(data_ready), 1);
        chk("t1_cready", 32'(ctrl_ready), 0);
        tick();
        data_valid = 1'b0;
        chk("t1_le", 32'(load_enable), 1);
        chk("t1_pin", 32'(parallel_in), 32'h2AA);
        chk("t1_src", 32'(src), 1);
        chk("t1_busy", 32'(busy), 1);
        prev = 10'h2AA;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_cnt", 32'(bit_cnt), 32'(i));
            chk("t1_le0", 32'(load_enable), 0);
            chk("t1_done", 32'(sym_done), 32'(i == 9));
            chk("t1_ser", 32'(serial_out), 32'(prev[i]));
            chk("t1_nordy", 32'(data_ready), 0);
        end

        // 3: nothing valid -> idle fill frames, every 11 cycles
        for (int f = 0; f < 2; f++) begin
            tick();
            chk("t3_le", 32'(load_enable), 1);
            chk("t3_pin", 32'(parallel_in), 32'h354);
            chk("t3_src", 32'(src), 0);
            chk("t3_ser_load", 32'(serial_out), 0);
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("t3_le0", 32'(load_enable), 0);
                chk("t3_ready", 32'({ctrl_ready, data_ready}), 0);
            end
        end
        // At the last SHIFT cycle of the second idle frame
        chk("t3_done", 32'(sym_done), 1);
        tick();
        chk("t3_le2", 32'(load_enable), 1);
        chk("t3_src2", 32'(src), 0);

        // 2: back-to-back data frames, one ready per frame
        prev = 10'h354;
        for (int f = 0; f < 3; f++) begin
            data_valid = 1'b1; data_sym = syms[f];
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("t2_ser", 32'(serial_out), 32'(prev[i]));
                chk("t2_le0", 32'(load_enable), 0);
                #1;
                chk("t2_dready", 32'(data_ready), 32'(i == 9));
            end
            tick();
            chk("t2_le", 32'(load_enable), 1);
            chk("t2_pin", 32'(parallel_in), 32'(syms[f]));
            chk("t2_src", 32'(src), 1);
            prev = syms[f];
        end

        // 4: both sources valid for 3 frames
        ctrl_valid = 1'b1; ctrl_sym = 10'h0AB; data_valid = 1'b1; data_sym = 10'h1CD;
        for (int g = 0; g < 3; g++) begin
`ifdef RR_ARB_EN
            exp_ctrl = (g != 1);
`else
            exp_ctrl = 1'b1;
`endif
            for (int i = 0; i < 10; i++) begin
                tick();
                chk("t4_ser", 32'(serial_out), 32'(prev[i]));
            end
            #1;
            chk("t4_cready", 32'(ctrl_ready), 32'(exp_ctrl));
            chk("t4_dready", 32'(data_ready), 32'(!exp_ctrl));
            tick();
            chk("t4_pin", 32'(parallel_in), exp_ctrl ? 32'h0AB : 32'h1CD);
            chk("t4_src", 32'(src), exp_ctrl ? 32'd2 : 32'd1);
            prev = exp_ctrl ? 10'h0AB : 10'h1CD;
        end

        // 5: enable dropped mid-SHIFT
        ctrl_valid = 1'b0; data_valid = 1'b1; data_sym = 10'h3C3;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_cnt4", 32'(bit_cnt), 4);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_nordy", 32'(data_ready), 0);
        end
        chk("t5_cnt9", 32'(bit_cnt), 9);
        chk("t5_done", 32'(sym_done), 1);
        tick();
        chk("t5_busy", 32'(busy), 0);
        chk("t5_le", 32'(load_enable), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_hold_le", 32'(load_enable), 0);
            chk("t5_hold_rdy", 32'(data_ready), 0);
        end
        enable = 1'b1;
        #1;
        chk("t5_regrant", 32'(data_ready), 1);
        tick();
        chk("t5_le2", 32'(load_enable), 1);
        chk("t5_pin", 32'(parallel_in), 32'h3C3);

        // 6: reset during SHIFT
        for (int i = 0; i < 6; i++) tick();
        chk("t6_cnt5", 32'(bit_cnt), 5);
        rst = 1'b1;
        tick();
        chk("t6_busy", 32'(busy), 0);
        chk("t6_le", 32'(load_enable), 0);
        chk("t6_pin", 32'(parallel_in), 0);
        chk("t6_src", 32'(src), 0);
        chk("t6_cnt", 32'(bit_cnt), 0);
        rst = 1'b0;
        #1;
        chk("t6_dready", 32'(data_ready), 1);
        tick();
        chk("t6_le2", 32'(load_enable), 1);
        chk("t6_pin2", 32'(parallel_in), 32'h3C3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
